// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage sitting directly upstream of the instruction ROM.
//
// Owns the PC and drives it straight out as the ROM read address. The ROM returns its word
// combinationally, and that word is captured together with its PC into a 2-entry skid queue.
// The head of the queue drives decode over a valid/ready handshake. Redirects from later
// stages flush the queue and load a new PC. A misaligned redirect target latches a sticky
// fault, which halts fetch until reset.
//
// Ports
//   clk             clock; all state updates on posedge
//   reset_n         synchronous active-low reset
//   rom_address     byte address to the ROM (always equals the PC register)
//   rom_data        32-bit word returned combinationally by the ROM for rom_address
//   out_valid       queue head holds a fetched instruction
//   out_ready       decode accepts the head this cycle
//   out_pc          PC of the head instruction
//   out_instr       instruction word at the head
//   redirect_valid  later stage requests a PC change (overrides pop and fetch)
//   redirect_pc     new PC target
//   fault           sticky: a misaligned redirect was received and fetch is halted
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } ent_t;

  // The queue is kept as a shift structure with entry 0 always the head, so out_* come
  // straight from flops and stay stable for as long as the head is not popped.
  ent_t [1:0]        ent_q, ent_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;

  logic redir_take;
  logic redir_bad;
  logic pop;
  logic fetch;
  ent_t new_ent;

  // Once faulted, a redirect is ignored entirely. Only reset leaves the fault state.
  assign redir_take = redirect_valid & ~fault_q;
  assign redir_bad  = redirect_pc[1:0] != 2'b00;

  // A handshake that coincides with a redirect is void, so it does not count as a pop.
  assign pop   = (cnt_q != 2'd0) & out_ready & ~redirect_valid;
  assign fetch = ~fault_q & ~redirect_valid & ((cnt_q != 2'd2) | pop);

  // rom_data is only ever written into state behind fetch, so the ROM word is don't-care
  // in every other cycle.
  assign new_ent = '{pc: pc_q, instr: rom_data};

  always_comb begin
    pc_d    = pc_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (redir_take) begin
      cnt_d = 2'd0;
      if (redir_bad) fault_d = 1'b1;
      else           pc_d    = redirect_pc;
    end else begin
      // The PC wraps naturally at 2**ADDR_W.
      if (fetch) pc_d = pc_q + ADDR_W'(4);
      unique case ({fetch, pop})
        2'b10: begin
          // Without a pop the queue has a free slot, and that slot sits at index count.
          ent_d[cnt_q[0]] = new_ent;
          cnt_d           = cnt_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          cnt_d    = cnt_q - 2'd1;
        end
        2'b11: begin
          // Push and pop together: the count is unchanged and no bubble is inserted.
          if (cnt_q == 2'd2) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = new_ent;
          end else begin
            ent_d[0] = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Payload storage needs no reset; it is qualified by cnt_q everywhere it matters.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rom_address = pc_q;
  assign out_valid   = cnt_q != 2'd0;
  assign out_pc      = ent_q[0].pc;
  assign out_instr   = ent_q[0].instr;
  assign fault       = fault_q;

endmodule
